shape_ctrl: RTL and testbench

Sequencer for the `shape` pulse-shaping datapath. It accepts I/Q symbols from an upstream requester over a valid/ready handshake and zero-stuffs each symbol into `UPSAMPLE` samples for `shape`'s `xin`/`yin` inputs. After the last symbol of a burst it drives `FLUSH_CYCLES` zero samples to drain the filter tail. It also produces the clock-enable that gates `shape`'s clock, so the filter only toggles while a burst is live.

---
 rtl/shape_ctrl_if.sv | 13 +
 rtl/shape_ctrl.sv | 97 +++++++++
 tb/tb_shape_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shape_ctrl_if.sv
// Symbol handshake between an upstream requester and shape_ctrl.
// The requester drives valid and data. The sequencer drives ready.
interface shape_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             sym_valid;
  logic             sym_ready;
  logic [WIDTH-1:0] sym_x;
  logic [WIDTH-1:0] sym_y;

  modport master (output sym_valid, output sym_x, output sym_y, input sym_ready);
  modport slave  (input sym_valid, input sym_x, input sym_y, output sym_ready);
endinterface

// File: rtl/shape_ctrl.sv
// Sequencer for the shape pulse-shaping filter. It zero-stuffs each I/Q symbol
// to UPSAMPLE samples, then flushes the filter tail and drives shape's clock enable.
module shape_ctrl #(
  parameter int WIDTH        = 32,
  parameter int UPSAMPLE     = 8,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  shape_ctrl_if.slave      sym,
  output logic [WIDTH-1:0] xin_o,
  output logic [WIDTH-1:0] yin_o,
  output logic             shape_en,
  output logic             phase0,
  output logic             busy,
  output logic             burst_done
);
  localparam int PW = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(UPSAMPLE - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t        state;
  logic [PW-1:0] phase;
  logic [FW-1:0] flush_cnt;
  logic          xfer;

  always_comb begin
    sym.sym_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    sym.sym_ready = 1'b1;
        RUN:     sym.sym_ready = (phase == PHASE_LAST);
        FLUSH:   sym.sym_ready = 1'b1;
        default: sym.sym_ready = 1'b0;
      endcase
    end
  end

  assign xfer = sym.sym_valid && sym.sym_ready;

  // Every state that can accept a symbol loads it in the same way, so the
  // transfer is handled first. A transfer also takes priority over flush expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      flush_cnt  <= '0;
      xin_o      <= '0;
      yin_o      <= '0;
      shape_en   <= 1'b0;
      phase0     <= 1'b0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      if (xfer) begin
        state    <= RUN;
        phase    <= '0;
        xin_o    <= sym.sym_x;
        yin_o    <= sym.sym_y;
        phase0   <= 1'b1;
        shape_en <= 1'b1;
        busy     <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          RUN: begin
            xin_o  <= '0;
            yin_o  <= '0;
            phase0 <= 1'b0;
            if (phase == PHASE_LAST) begin
              state     <= FLUSH;
              phase     <= '0;
              flush_cnt <= FLUSH_LAST;
            end else begin
              phase <= phase + 1'b1;
            end
          end
          FLUSH: begin
            if (flush_cnt == '0) begin
              state      <= IDLE;
              shape_en   <= 1'b0;
              busy       <= 1'b0;
              burst_done <= 1'b1;
            end else begin
              flush_cnt <= flush_cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_shape_ctrl.sv
// Scoreboard bench for shape_ctrl: the expected per-cycle output trace is queued when
// stimulus is planned, then popped and compared on each falling edge.
`timescale 1ns/1ps
module tb_shape_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shape_ctrl_if #(.WIDTH(32)) sif ();
  shape_ctrl_if #(.WIDTH(32)) sif2 ();

  logic [31:0] xin_o, yin_o, xin2, yin2;
  logic shape_en, phase0, busy, burst_done;
  logic en2, p02, busy2, done2;

  shape_ctrl #(.WIDTH(32), .UPSAMPLE(8), .FLUSH_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .sym(sif), .xin_o(xin_o), .yin_o(yin_o),
    .shape_en(shape_en), .phase0(phase0), .busy(busy), .burst_done(burst_done));

  shape_ctrl #(.WIDTH(32), .UPSAMPLE(1), .FLUSH_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .sym(sif2), .xin_o(xin2), .yin_o(yin2),
    .shape_en(en2), .phase0(p02), .busy(busy2), .burst_done(done2));

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic p0, en, done, rdy;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic void push_sym(input logic [31:0] x, input logic [31:0] y,
                                   input int unsigned up);
    exp_t e;
    for (int unsigned k = 0; k < up; k++) begin
      e.x = (k == 0) ? x : '0;
      e.y = (k == 0) ? y : '0;
      e.p0 = (k == 0);
      e.en = 1'b1;
      e.done = 1'b0;
      e.rdy = (k == up - 1);
      sb.push_back(e);
    end
  endfunction

  function automatic void push_flush(input int unsigned n, input bit with_done);
    exp_t e;
    e.x = '0; e.y = '0; e.p0 = 1'b0; e.en = 1'b1; e.done = 1'b0; e.rdy = 1'b1;
    for (int unsigned k = 0; k < n; k++) sb.push_back(e);
    if (with_done) begin
      e.en = 1'b0; e.done = 1'b1;
      sb.push_back(e);
    end
  endfunction

  task automatic test_reset();
    #3;
    vectors++;
    if (xin_o !== '0 || yin_o !== '0 || shape_en !== 1'b0 || phase0 !== 1'b0 ||
        busy !== 1'b0 || burst_done !== 1'b0 || sif.sym_ready !== 1'b0 ||
        xin2 !== '0 || en2 !== 1'b0 || sif2.sym_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: x=%0d en=%b p0=%b busy=%b done=%b rdy=%b rdy2=%b, expected all 0",
               xin_o, shape_en, phase0, busy, burst_done, sif.sym_ready, sif2.sym_ready);
    end
    @(negedge clk); rst = 1'b0; #1;
    vectors++;
    if (sif.sym_ready !== 1'b1 || busy !== 1'b0 || sif2.sym_ready !== 1'b1 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: rdy=%b busy=%b rdy2=%b busy2=%b, expected rdy=1 busy=0",
               sif.sym_ready, busy, sif2.sym_ready, busy2);
    end
  endtask

  task automatic test_single();
    exp_t e;
    int idx = 0, en_cnt = 0, done_cnt = 0;
    push_sym(32'd46341, 32'd0, 8);
    push_flush(64, 1'b1);
    @(negedge clk); sif.sym_valid = 1'b1; sif.sym_x = 32'd46341; sif.sym_y = 32'd0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (xin_o !== e.x || yin_o !== e.y || phase0 !== e.p0 || shape_en !== e.en ||
          busy !== e.en || burst_done !== e.done || sif.sym_ready !== e.rdy) begin
        miscompares++;
        $display("FAIL single[%0d]: x=%0d y=%0d p0=%b en=%b busy=%b done=%b rdy=%b, expected x=%0d y=%0d p0=%b en=%b done=%b rdy=%b",
                 idx, xin_o, yin_o, phase0, shape_en, busy, burst_done, sif.sym_ready,
                 e.x, e.y, e.p0, e.en, e.done, e.rdy);
      end
      if (shape_en === 1'b1) en_cnt++;
      if (burst_done === 1'b1) done_cnt++;
      sif.sym_valid = 1'b0;
      idx++;
    end
    vectors++;
    if (en_cnt != 72 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL single_len: en_cycles=%0d done_pulses=%0d, expected 72 and 1", en_cnt, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int idx = 0, en_cnt = 0;
    for (int i = 0; i < 8; i++) push_sym(32'd46351, 32'd0, 8);
    push_flush(64, 1'b1);
    @(negedge clk); sif.sym_valid = 1'b1; sif.sym_x = 32'd46351; sif.sym_y = 32'd0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (xin_o !== e.x || yin_o !== e.y || phase0 !== e.p0 || shape_en !== e.en ||
          busy !== e.en || burst_done !== e.done || sif.sym_ready !== e.rdy) begin
        miscompares++;
        $display("FAIL b2b[%0d]: x=%0d y=%0d p0=%b en=%b busy=%b done=%b rdy=%b, expected x=%0d y=%0d p0=%b en=%b done=%b rdy=%b",
                 idx, xin_o, yin_o, phase0, shape_en, busy, burst_done, sif.sym_ready,
                 e.x, e.y, e.p0, e.en, e.done, e.rdy);
      end
      if (shape_en === 1'b1) en_cnt++;
      sif.sym_valid = (idx < 63);
      idx++;
    end
    vectors++;
    if (en_cnt != 128) begin
      miscompares++;
      $display("FAIL b2b_len: en_cycles=%0d, expected 128", en_cnt);
    end
  endtask

  task automatic test_flush_reenter();
    exp_t e;
    int idx = 0;
    push_sym(32'd1111, 32'd2222, 8);
    push_flush(10, 1'b0);
    push_sym(32'd3333, 32'd4444, 8);
    push_flush(64, 1'b1);
    @(negedge clk); sif.sym_valid = 1'b1; sif.sym_x = 32'd1111; sif.sym_y = 32'd2222;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (xin_o !== e.x || yin_o !== e.y || phase0 !== e.p0 || shape_en !== e.en ||
          busy !== e.en || burst_done !== e.done || sif.sym_ready !== e.rdy) begin
        miscompares++;
        $display("FAIL reenter[%0d]: x=%0d y=%0d p0=%b en=%b busy=%b done=%b rdy=%b, expected x=%0d y=%0d p0=%b en=%b done=%b rdy=%b",
                 idx, xin_o, yin_o, phase0, shape_en, busy, burst_done, sif.sym_ready,
                 e.x, e.y, e.p0, e.en, e.done, e.rdy);
      end
      sif.sym_valid = (idx == 17);
      sif.sym_x = 32'd3333; sif.sym_y = 32'd4444;
      idx++;
    end
  endtask

  task automatic test_same_edge();
    exp_t e;
    int idx = 0;
    push_sym(32'd5, 32'd6, 8);
    push_flush(64, 1'b0);
    push_sym(32'd7, 32'd8, 8);
    push_flush(64, 1'b1);
    @(negedge clk); sif.sym_valid = 1'b1; sif.sym_x = 32'd5; sif.sym_y = 32'd6;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (xin_o !== e.x || yin_o !== e.y || phase0 !== e.p0 || shape_en !== e.en ||
          busy !== e.en || burst_done !== e.done || sif.sym_ready !== e.rdy) begin
        miscompares++;
        $display("FAIL same_edge[%0d]: x=%0d y=%0d p0=%b en=%b busy=%b done=%b rdy=%b, expected x=%0d y=%0d p0=%b en=%b done=%b rdy=%b",
                 idx, xin_o, yin_o, phase0, shape_en, busy, burst_done, sif.sym_ready,
                 e.x, e.y, e.p0, e.en, e.done, e.rdy);
      end
      sif.sym_valid = (idx == 71);
      sif.sym_x = 32'd7; sif.sym_y = 32'd8;
      idx++;
    end
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t < 2; t++) begin
      int off = (t == 0) ? 0 : 20;
      int bad = 0;
      @(negedge clk); sif.sym_valid = 1'b1; sif.sym_x = 32'd777; sif.sym_y = 32'd555;
      @(negedge clk); sif.sym_valid = 1'b0;
      repeat (off) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (xin_o !== '0 || yin_o !== '0 || shape_en !== 1'b0 || phase0 !== 1'b0 ||
          busy !== 1'b0 || burst_done !== 1'b0 || sif.sym_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid[%0d]: x=%0d y=%0d en=%b p0=%b busy=%b done=%b rdy=%b, expected all 0",
                 off, xin_o, yin_o, shape_en, phase0, busy, burst_done, sif.sym_ready);
      end
      @(negedge clk); rst = 1'b0; #1;
      vectors++;
      if (sif.sym_ready !== 1'b1 || busy !== 1'b0 || shape_en !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_release[%0d]: rdy=%b busy=%b en=%b, expected 1 0 0",
                 off, sif.sym_ready, busy, shape_en);
      end
      repeat (80) begin
        @(negedge clk);
        if (burst_done !== 1'b0 || shape_en !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL reset_mid_quiet[%0d]: %0d active cycles after reset, expected 0", off, bad);
      end
    end
  endtask

  task automatic test_upsample1();
    exp_t e;
    int idx = 0, en_cnt = 0;
    for (int k = 1; k <= 4; k++) push_sym(32'(k), 32'(10 * k), 1);
    push_flush(1, 1'b1);
    @(negedge clk); sif2.sym_valid = 1'b1; sif2.sym_x = 32'd1; sif2.sym_y = 32'd10;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (xin2 !== e.x || yin2 !== e.y || p02 !== e.p0 || en2 !== e.en ||
          busy2 !== e.en || done2 !== e.done || sif2.sym_ready !== e.rdy) begin
        miscompares++;
        $display("FAIL up1[%0d]: x=%0d y=%0d p0=%b en=%b busy=%b done=%b rdy=%b, expected x=%0d y=%0d p0=%b en=%b done=%b rdy=%b",
                 idx, xin2, yin2, p02, en2, busy2, done2, sif2.sym_ready,
                 e.x, e.y, e.p0, e.en, e.done, e.rdy);
      end
      if (en2 === 1'b1) en_cnt++;
      if (idx < 3) begin
        sif2.sym_x = 32'(idx + 2);
        sif2.sym_y = 32'(10 * (idx + 2));
      end else begin
        sif2.sym_valid = 1'b0;
      end
      idx++;
    end
    vectors++;
    if (en_cnt != 5) begin
      miscompares++;
      $display("FAIL up1_len: en_cycles=%0d, expected 5", en_cnt);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.sym_valid = 1'b0;  sif.sym_x = '0;  sif.sym_y = '0;
    sif2.sym_valid = 1'b0; sif2.sym_x = '0; sif2.sym_y = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_flush_reenter();
    test_same_edge();
    test_reset_mid();
    test_upsample1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
